// File: rtl/noc_input_port_ctrl.sv
// Per-input-port controller for a mesh router.
// Buffers incoming flits, looks up the route for each head flit, requests and
// holds an output port from the switch allocator, then streams the packet's
// flits to the crossbar until the tail flit leaves.
module noc_input_port_ctrl #(
  parameter int MESH_SIZE = 3,
  parameter int FLIT_W    = 16,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MESH_SIZE-1:0] router_x,
  input  logic [MESH_SIZE-1:0] router_y,
  input  logic                 in_valid,
  input  logic [FLIT_W-1:0]    in_flit,
  output logic                 in_ready,
  output logic [MESH_SIZE-1:0] rt_dest_x,
  output logic [MESH_SIZE-1:0] rt_dest_y,
  output logic                 rt_read_request,
  input  logic [2:0]           rt_next_hop,
  output logic                 sa_req,
  output logic [2:0]           sa_port,
  input  logic                 sa_grant,
  output logic                 out_valid,
  output logic [FLIT_W-1:0]    out_flit,
  output logic [2:0]           out_port,
  input  logic                 out_ready,
  output logic                 drop_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    ALLOC,
    ACTIVE
  } state_t;

  state_t                 state;
  logic [FLIT_W-1:0]      mem [DEPTH];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [CW-1:0]          count;
  logic [FLIT_W-1:0]      head_flit;
  logic                   empty;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   head_is_start;
  logic                   head_is_end;
  logic [MESH_SIZE-1:0]   dest_x;
  logic [MESH_SIZE-1:0]   dest_y;
  logic [2:0]             port;

  // FIFO status and head-of-queue decode
  always_comb begin
    head_flit     = mem[rd_ptr];
    empty         = (count == '0);
    full          = (count == CW'(DEPTH));
    push          = in_valid & ~full;
    // Type 01/11 starts a packet, type 10/11 ends one.
    head_is_start = head_flit[FLIT_W-2];
    head_is_end   = head_flit[FLIT_W-1];
  end

  // Pop decision: discard stray non-head flits in IDLE, stream in ACTIVE
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = ~empty & ~head_is_start;
      ACTIVE:  pop = ~empty & out_ready;
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_flit;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Packet FSM: route lookup, port allocation, streaming, drop pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      dest_x   <= '0;
      dest_y   <= '0;
      port     <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            if (head_is_start) begin
              dest_x <= head_flit[2*MESH_SIZE-1:MESH_SIZE];
              dest_y <= head_flit[MESH_SIZE-1:0];
              state  <= ROUTE;
            end else begin
              drop_err <= 1'b1;
            end
          end
        end
        ROUTE: begin
          if ((dest_x == router_x) && (dest_y == router_y)) begin
            port <= '0;
          end else begin
            port <= rt_next_hop;
          end
          state <= ALLOC;
        end
        ALLOC: begin
          if (sa_grant) begin
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (pop && head_is_end) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from registered state and FIFO occupancy
  always_comb begin
    in_ready        = ~full;
    rt_dest_x       = dest_x;
    rt_dest_y       = dest_y;
    rt_read_request = (state == ROUTE);
    sa_req          = (state == ALLOC) || (state == ACTIVE);
    sa_port         = port;
    out_port        = port;
    out_valid       = (state == ACTIVE) && !empty;
    out_flit        = out_valid ? head_flit : '0;
  end

endmodule

// File: tb/tb_noc_input_port_ctrl.sv
// Self-checking bench for noc_input_port_ctrl: queue-based packet model,
// per-cycle output comparison, directed latency/boundary scenarios and a
// randomized traffic phase.
module tb_noc_input_port_ctrl;

  localparam int M     = 3;
  localparam int W     = 16;
  localparam int DEPTH = 4;

  localparam int P_IDLE   = 0;
  localparam int P_ROUTE  = 1;
  localparam int P_ALLOC  = 2;
  localparam int P_ACTIVE = 3;

  logic         clk;
  logic         rst_n;
  logic [M-1:0] router_x;
  logic [M-1:0] router_y;
  logic         in_valid;
  logic [W-1:0] in_flit;
  logic         in_ready;
  logic [M-1:0] rt_dest_x;
  logic [M-1:0] rt_dest_y;
  logic         rt_read_request;
  logic [2:0]   rt_next_hop;
  logic         sa_req;
  logic [2:0]   sa_port;
  logic         sa_grant;
  logic         out_valid;
  logic [W-1:0] out_flit;
  logic [2:0]   out_port;
  logic         out_ready;
  logic         drop_err;

  noc_input_port_ctrl #(.MESH_SIZE(M), .FLIT_W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .router_x(router_x), .router_y(router_y),
    .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .rt_dest_x(rt_dest_x), .rt_dest_y(rt_dest_y),
    .rt_read_request(rt_read_request), .rt_next_hop(rt_next_hop),
    .sa_req(sa_req), .sa_port(sa_port), .sa_grant(sa_grant),
    .out_valid(out_valid), .out_flit(out_flit), .out_port(out_port),
    .out_ready(out_ready), .drop_err(drop_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] mq[$];
  int           mph    = P_IDLE;
  logic [M-1:0] mdx    = '0;
  logic [M-1:0] mdy    = '0;
  logic [2:0]   mport  = '0;
  bit           mdrop  = 0;
  bit           live   = 0;
  bit           m_pushed = 0;
  int           m_pops = 0;

  initial forever begin
    @(posedge clk);
    m_pushed = 0;
    if (!rst_n) begin
      live = 1;
      mq.delete();
      mph = P_IDLE; mdx = '0; mdy = '0; mport = '0; mdrop = 0;
    end else begin
      bit push_ok;
      bit do_pop;
      int nxt;
      push_ok = in_valid && (mq.size() != DEPTH);
      do_pop  = 0;
      nxt     = mph;
      mdrop   = 0;
      if (mph == P_IDLE) begin
        if (mq.size() > 0) begin
          if (mq[0][W-2]) begin
            mdx = mq[0][2*M-1:M];
            mdy = mq[0][M-1:0];
            nxt = P_ROUTE;
          end else begin
            do_pop = 1;
            mdrop  = 1;
          end
        end
      end else if (mph == P_ROUTE) begin
        mport = (mdx == router_x && mdy == router_y) ? 3'd0 : rt_next_hop;
        nxt   = P_ALLOC;
      end else if (mph == P_ALLOC) begin
        if (sa_grant) nxt = P_ACTIVE;
      end else begin
        if (mq.size() > 0 && out_ready) begin
          do_pop = 1;
          m_pops++;
          if (mq[0][W-1]) nxt = P_IDLE;
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (push_ok) begin
        mq.push_back(in_flit);
        m_pushed = 1;
      end
      mph = nxt;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (live) begin
      bit exp_req;
      bit exp_ov;
      exp_req = (mph == P_ALLOC) || (mph == P_ACTIVE);
      exp_ov  = (mph == P_ACTIVE) && (mq.size() > 0);
      chk("in_ready", in_ready, (mq.size() != DEPTH));
      chk("rt_read_request", rt_read_request, (mph == P_ROUTE));
      chk("rt_dest_x", rt_dest_x, mdx);
      chk("rt_dest_y", rt_dest_y, mdy);
      chk("sa_req", sa_req, exp_req);
      if (exp_req) begin
        chk("sa_port", sa_port, mport);
        chk("out_port", out_port, mport);
      end
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) chk("out_flit", out_flit, mq[0]);
      chk("drop_err", drop_err, mdrop);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [W-1:0] src[$];
  bit           gaps = 0;

  function automatic logic [W-1:0] mk(input logic [1:0] t, input int x, input int y);
    logic [7:0] mid;
    mid = 8'($urandom);
    return {t, mid, 3'(x), 3'(y)};
  endfunction

  task automatic drive();
    if (src.size() > 0) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_flit  = src[0];
    end else begin
      in_valid = 1'b0;
      in_flit  = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    if (m_pushed && src.size() > 0) void'(src.pop_front());
    drive();
  endtask

  task automatic do_reset();
    src.delete();
    rst_n = 1'b0;
    drive();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic gen_pkt();
    int r;
    int nb;
    r = $urandom_range(0, 9);
    router_x = 3'($urandom_range(0, 3));
    router_y = 3'($urandom_range(0, 3));
    if (r == 0) begin
      src.push_back(mk($urandom_range(0, 1) ? 2'b10 : 2'b00, 0, 0));
    end else if (r < 4) begin
      src.push_back(mk(2'b11, $urandom_range(0, 3), $urandom_range(0, 3)));
    end else begin
      src.push_back(mk(2'b01, $urandom_range(0, 3), $urandom_range(0, 3)));
      nb = $urandom_range(0, 4);
      for (int i = 0; i < nb; i++)
        src.push_back(mk(($urandom_range(0, 4) == 0) ? 2'b01 : 2'b00,
                         $urandom_range(0, 7), $urandom_range(0, 7)));
      src.push_back(mk(2'b10, $urandom_range(0, 7), $urandom_range(0, 7)));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] f1;
    int base;
    rst_n = 1'b0; router_x = '0; router_y = '0;
    in_valid = 1'b0; in_flit = '0; rt_next_hop = 3'b001;
    sa_grant = 1'b0; out_ready = 1'b0;

    // Reset with in_valid held high
    @(negedge clk);
    in_valid = 1'b1;
    in_flit  = 16'h4000;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sa_req", sa_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rt_req", rt_read_request, 0);
    chk("rst_drop_err", drop_err, 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("rst_count0_out_valid", out_valid, 0);

    // Single-flit packet, router (1,1) -> dest (1,3), next hop E
    router_x = 3'd1; router_y = 3'd1; rt_next_hop = 3'b100;
    sa_grant = 1'b1; out_ready = 1'b1;
    src.push_back(mk(2'b11, 1, 3));
    f1 = src[0];
    drive();
    tick();
    chk("t1_e0_rt_req", rt_read_request, 0);
    tick();
    chk("t1_route_req", rt_read_request, 1);
    chk("t1_route_dx", rt_dest_x, 1);
    chk("t1_route_dy", rt_dest_y, 3);
    tick();
    chk("t1_alloc_rt_req", rt_read_request, 0);
    chk("t1_alloc_sa_req", sa_req, 1);
    chk("t1_alloc_port", sa_port, 3'b100);
    tick();
    chk("t1_active_ov", out_valid, 1);
    chk("t1_active_port", out_port, 3'b100);
    chk("t1_active_flit", out_flit, f1);
    tick();
    chk("t1_idle_sa_req", sa_req, 0);
    chk("t1_idle_ov", out_valid, 0);

    // Local delivery
    router_x = 3'd2; router_y = 3'd2; rt_next_hop = 3'b001;
    src.push_back(mk(2'b01, 2, 2));
    src.push_back(mk(2'b10, 5, 5));
    drive();
    tick(); tick(); tick();
    chk("local_sa_req", sa_req, 1);
    chk("local_sa_port", sa_port, 3'b000);
    repeat (6) tick();

    // Stray body flit in IDLE is dropped, then a head routes normally
    src.push_back(mk(2'b00, 1, 1));
    drive();
    tick();
    tick();
    chk("drop_pulse", drop_err, 1);
    chk("drop_no_rt", rt_read_request, 0);
    tick();
    chk("drop_pulse_end", drop_err, 0);
    chk("drop_no_rt2", rt_read_request, 0);
    rt_next_hop = 3'b010;
    src.push_back(mk(2'b11, 0, 0));
    drive();
    repeat (8) tick();

    // FIFO fills while stuck in ALLOC
    router_x = 3'd0; router_y = 3'd0; rt_next_hop = 3'b011;
    sa_grant = 1'b0; out_ready = 1'b1;
    src.push_back(mk(2'b01, 3, 0));
    for (int i = 0; i < 4; i++) src.push_back(mk(2'b00, i, i));
    src.push_back(mk(2'b10, 0, 0));
    drive();
    tick(); tick(); tick();
    chk("full_3_ready", in_ready, 1);
    tick();
    chk("full_4_ready", in_ready, 0);
    tick();
    chk("full_hold_ready", in_ready, 0);
    sa_grant = 1'b1;
    tick();
    chk("full_active_ready", in_ready, 0);
    chk("full_active_ov", out_valid, 1);
    tick();
    chk("full_after_pop_ready", in_ready, 1);
    repeat (12) tick();

    // 4-flit packet, grant delayed 5 cycles, out_ready toggling
    sa_grant = 1'b0; out_ready = 1'b1;
    router_x = 3'd3; router_y = 3'd3; rt_next_hop = 3'b001;
    src.push_back(mk(2'b01, 1, 2));
    src.push_back(mk(2'b00, 7, 7));
    src.push_back(mk(2'b00, 6, 6));
    src.push_back(mk(2'b10, 5, 5));
    drive();
    for (int i = 0; i < 20 && mph != P_ALLOC; i++) tick();
    chk("pkt4_reached_alloc", (mph == P_ALLOC), 1);
    repeat (5) begin tick(); out_ready = ~out_ready; end
    sa_grant = 1'b1;
    repeat (16) begin tick(); out_ready = ~out_ready; end
    chk("pkt4_done_sa_req", sa_req, 0);
    chk("pkt4_done_ov", out_valid, 0);

    // Reset mid-packet after two of four flits
    sa_grant = 1'b1; out_ready = 1'b1;
    src.push_back(mk(2'b01, 0, 1));
    src.push_back(mk(2'b00, 1, 1));
    src.push_back(mk(2'b00, 2, 2));
    src.push_back(mk(2'b10, 3, 3));
    drive();
    base = m_pops;
    for (int i = 0; i < 40 && m_pops < base + 2; i++) tick();
    chk("rstmid_two_popped", (m_pops >= base + 2), 1);
    chk("rstmid_active", sa_req, 1);
    src.delete();
    rst_n = 1'b0;
    drive();
    tick();
    chk("rstmid_sa_req", sa_req, 0);
    chk("rstmid_ov", out_valid, 0);
    chk("rstmid_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();
    tick();
    chk("rstmid_empty_idle", sa_req | out_valid | rt_read_request, 0);

    // Randomized traffic
    do_reset();
    gaps = 1;
    for (int c = 0; c < 4000; c++) begin
      if (src.size() == 0 && $urandom_range(0, 2) == 0) gen_pkt();
      rt_next_hop = 3'($urandom_range(1, 4));
      sa_grant    = ($urandom_range(0, 2) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/noc_input_port_ctrl.md
Name: noc_input_port_ctrl

Overview:
- Per-input-port controller of a mesh router; one instance sits on each router input (N/S/E/W/local).
- Buffers incoming flits and issues the route lookup for each head flit to the router's routing table. Drives the `rt_read_request` / destination side of that table interface and consumes the returned `next_hop`.
- Requests and holds an output port from the switch allocator, then streams the packet's flits to the crossbar until the tail flit leaves.

Parameters:
- MESH_SIZE, 3, bits per X/Y coordinate.
- FLIT_W, 16, flit width. [FLIT_W-1:FLIT_W-2] is the type field: 01 head, 00 body, 10 tail, 11 head+tail (single-flit packet). On head flits, dest_x=[2*MESH_SIZE-1:MESH_SIZE] and dest_y=[MESH_SIZE-1:0].
- DEPTH, 4, FIFO depth in flits; power of 2, >=2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- router_x  in  MESH_SIZE  this router's X address
- router_y  in  MESH_SIZE  this router's Y address
- in_valid  in  1  upstream flit valid
- in_flit  in  FLIT_W  upstream flit
- in_ready  out  1  FIFO can accept a flit
- rt_dest_x  out  MESH_SIZE  destination X to routing table
- rt_dest_y  out  MESH_SIZE  destination Y to routing table
- rt_read_request  out  1  lookup strobe to routing table
- rt_next_hop  in  3  routing table result (001 N, 010 S, 011 W, 100 E)
- sa_req  out  1  output-port request/hold to switch allocator
- sa_port  out  3  requested port (000 LOCAL, else the next_hop code)
- sa_grant  in  1  allocator grant for sa_port
- out_valid  out  1  flit valid to crossbar
- out_flit  out  FLIT_W  flit to crossbar
- out_port  out  3  crossbar select, equals sa_port
- out_ready  in  1  downstream accepts flit
- drop_err  out  1  one-cycle pulse: non-head flit discarded in IDLE

Behaviour:
- Single clock domain. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clk edge):
  - FIFO flushed: rd/wr pointers and count go to 0.
  - State goes to IDLE.
  - All outputs are 0, except in_ready, which is 1.
  - This applies mid-packet too; a partially forwarded packet is abandoned.
- FIFO:
  - in_ready = (count != DEPTH).
  - Push when in_valid & in_ready.
  - Pop only as described per state below.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged. When full, in_ready=0 even if a pop happens that cycle.
  - Head-of-FIFO flit is visible combinationally.
- IDLE:
  - If the FIFO is non-empty and the head flit type is 01 or 11: latch dest_x/dest_y into registers, go to ROUTE.
  - If non-empty and the type is 00 or 10: pop it, pulse drop_err for one cycle, stay in IDLE.
- ROUTE (exactly 1 cycle):
  - rt_read_request=1; rt_dest_x/y = latched destination.
  - At the clock edge, latch the port: 000 if dest == (router_x, router_y), else rt_next_hop.
  - Go to ALLOC.
  - rt_dest_x/y hold their value outside ROUTE; rt_read_request=0 outside ROUTE.
- ALLOC:
  - sa_req=1, sa_port = latched port.
  - Stay until sa_grant=1 is sampled, then go to ACTIVE.
- ACTIVE:
  - sa_req stays 1 (port held); out_port = sa_port.
  - out_valid = FIFO non-empty; out_flit = FIFO head.
  - Pop on out_valid & out_ready.
  - If the popped flit's type is 10 or 11: go to IDLE next cycle, deasserting sa_req and out_valid.
  - sa_grant is ignored in ACTIVE.
- Latency, head flit of a single-flit packet into an empty FIFO, pushed at edge E0, with grant and out_ready held high:
  - ROUTE in the cycle after E1;
  - ALLOC after E2;
  - ACTIVE with out_valid=1 after E3;
  - pop at E4.
- Boundaries:
  - An empty FIFO in ACTIVE stalls with out_valid=0 and the port still held.
  - A flit with type 01/11 arriving mid-packet is forwarded as ordinary data; there is no nesting.
  - Upstream may keep pushing while the controller is in ROUTE or ALLOC.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1; sa_req, out_valid, rt_read_request and drop_err all 0; count 0 after release.
- Router (1,1), single flit type 11 with dest (1,3), rt_next_hop=100, grant the cycle sa_req rises -> rt_read_request for exactly 1 cycle with rt_dest=(1,3); sa_port=out_port=100; out_valid 2 cycles after ROUTE; IDLE after pop.
- Local delivery: router (2,2), head dest (2,2), rt_next_hop=001 driven -> sa_port=000.
- 4-flit packet (head, body, body, tail) with out_ready toggling 1,0,1,0… and grant delayed 5 cycles -> flits out in order; sa_req high continuously from ALLOC until after the tail pop.
- DEPTH=4 full: push 6 flits back-to-back while in ALLOC -> in_ready=0 after 4 pushes; in_ready returns 1 the cycle after the first pop.
- Body flit (type 00) at IDLE -> popped, drop_err pulses 1 cycle, no rt_read_request; a following head is routed normally.
- Assert rst_n=0 in ACTIVE after 2 of 4 flits -> next cycle IDLE, sa_req=0, FIFO empty.
